stream_mux_2_1: RTL

- Merges two packet streams (inputs 0 and 1) onto one output stream using valid/ready handshakes.
- Arbitrates round-robin at packet boundaries; once a source is granted, it keeps the output until its last beat.
- Output is registered, one beat deep.
- This is the gather side of the codebase's 1:2 demultiplexer, used wherever two producers share one consumer.

---
 rtl/stream_mux_2_1_pkg.sv | 16 +
 rtl/stream_mux_2_1_rr_arbiter_2.sv | 29 ++
 rtl/stream_mux_2_1.sv | 110 +++++++++++
 3 files changed

// File: rtl/stream_mux_2_1_pkg.sv
// rtl/stream_mux_2_1_pkg.sv - shared state encodings and defaults for the 2:1 stream mux
package stream_mux_2_1_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  function automatic state_e lock_state(input logic idx);
    return idx ? LOCK1 : LOCK0;
  endfunction

endpackage

// File: rtl/stream_mux_2_1_rr_arbiter_2.sv
// rtl/stream_mux_2_1_rr_arbiter_2.sv - two-requester round-robin grant with packet-end pointer update
module stream_mux_2_1_rr_arbiter_2 (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic pkt_done,
  input  logic done_idx,
  output logic grant_valid,
  output logic grant_idx
);

  logic rr;

  always_comb begin
    grant_valid = req0 | req1;
    grant_idx   = (req0 && req1) ? rr : req1;
  end

  // The source that just finished yields priority to the other one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr <= 1'b0;
    end else if (pkt_done) begin
      rr <= ~done_idx;
    end
  end

endmodule

// File: rtl/stream_mux_2_1.sv
// rtl/stream_mux_2_1.sv - 2:1 packet stream mux, round-robin at packet boundaries, registered output
module stream_mux_2_1
  import stream_mux_2_1_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a0_data,
  input  logic             a0_valid,
  input  logic             a0_last,
  output logic             a0_ready,
  input  logic [WIDTH-1:0] a1_data,
  input  logic             a1_valid,
  input  logic             a1_last,
  output logic             a1_ready,
  output logic [WIDTH-1:0] y_data,
  output logic             y_valid,
  output logic             y_last,
  output logic             y_src,
  input  logic             y_ready
);

  state_e state;
  state_e state_nxt;
  logic   space;
  logic   xfer0;
  logic   xfer1;
  logic   pkt_done;
  logic   grant_valid;
  logic   grant_idx;

  assign space    = !y_valid || y_ready;
  assign xfer0    = a0_valid && a0_ready;
  assign xfer1    = a1_valid && a1_ready;
  assign pkt_done = (xfer0 && a0_last) || (xfer1 && a1_last);

  stream_mux_2_1_rr_arbiter_2 u_arb (
    .clk         (clk),
    .rst         (rst),
    .req0        (a0_valid),
    .req1        (a1_valid),
    .pkt_done    (pkt_done),
    .done_idx    (xfer1),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Gaps inside a packet keep the lock; only an accepted last beat releases it.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          state_nxt = lock_state(grant_idx);
        end
      end
      LOCK0: begin
        if (xfer0 && a0_last) begin
          state_nxt = IDLE;
        end
      end
      LOCK1: begin
        if (xfer1 && a1_last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    a0_ready = 1'b0;
    a1_ready = 1'b0;
    case (state)
      LOCK0:   a0_ready = space;
      LOCK1:   a1_ready = space;
      default: begin
        a0_ready = 1'b0;
        a1_ready = 1'b0;
      end
    endcase
  end

  // One-deep output register; data is held when the beat drains without a refill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_data  <= '0;
      y_valid <= 1'b0;
      y_last  <= 1'b0;
      y_src   <= 1'b0;
    end else if (xfer0 || xfer1) begin
      y_data  <= xfer1 ? a1_data : a0_data;
      y_last  <= xfer1 ? a1_last : a0_last;
      y_src   <= xfer1;
      y_valid <= 1'b1;
    end else if (y_ready) begin
      y_valid <= 1'b0;
    end
  end

endmodule
